// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and constants for the RV32M multiply/divide sequencer
package muldiv_pkg;

    localparam int MD_DATA_WIDTH = 32;
    localparam int MD_CNT_W      = $clog2(MD_DATA_WIDTH);

    localparam logic [MD_DATA_WIDTH-1:0] MD_DIV0_QUOT = '1;
    localparam logic [MD_DATA_WIDTH-1:0] MD_OVF_QUOT  = {1'b1, {(MD_DATA_WIDTH-1){1'b0}}};
    localparam logic [MD_DATA_WIDTH-1:0] MD_OVF_REM   = '0;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_DONE
    } md_state_e;

    typedef enum logic {
        MD_MODE_MUL,
        MD_MODE_DIV
    } md_mode_e;

endpackage

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp: one-bit-per-cycle unsigned shift-add multiplier / restoring divider
module muldiv_iter_dp
    import muldiv_pkg::*;
#(
    parameter int W = MD_DATA_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  md_mode_e     mode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    logic [W-1:0] m;
    logic [W:0]   sum;
    logic [W:0]   sh;
    logic [W:0]   diff;

    // Partial-product add and trial subtract; diff[W] set means the trial went negative
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        sh   = {hi, lo[W-1]};
        diff = sh - {1'b0, m};
    end

    // hi:lo is the product pair for multiply and the remainder:quotient pair for divide
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            m  <= '0;
        end else if (load) begin
            hi <= '0;
            lo <= (mode == MD_MODE_DIV) ? a : b;
            m  <= (mode == MD_MODE_DIV) ? b : a;
        end else if (step) begin
            if (mode == MD_MODE_DIV)
                {hi, lo} <= diff[W] ? {sh[W-1:0], lo[W-2:0], 1'b0} : {diff[W-1:0], lo[W-2:0], 1'b1};
            else
                {hi, lo} <= {sum, lo[W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: RV32M MUL/DIV/REM sequencer; define MULDIV_ZERO_BYPASS_EN to skip iteration on zero operands
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = MD_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] srca,
    input  logic [DATA_WIDTH-1:0] srcb,
    input  logic                  flush,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    md_state_e               state, state_d;
    md_op_e                  op_q;
    logic [DATA_WIDTH-1:0]   a_q, b_q, mag_a, mag_b;
    logic [DATA_WIDTH-1:0]   spec_val, spec_val_q, res_q;
    logic [DATA_WIDTH-1:0]   hi, lo, quot, rem, fin;
    logic [2*DATA_WIDTH-1:0] prod;
    logic [MD_CNT_W-1:0]     cnt;
    logic is_div, sa, sb, neg, neg_q, div0, ovf, zbyp, special, spec_q, last;

    // Operand signedness, magnitudes, result sign and early-exit classification
    always_comb begin
        is_div  = op_q[2];
        sa      = (is_div ? !op_q[0] : !(op_q[1] && op_q[0])) && a_q[DATA_WIDTH-1];
        sb      = (is_div ? !op_q[0] : !op_q[1]) && b_q[DATA_WIDTH-1];
        mag_a   = sa ? -a_q : a_q;
        mag_b   = sb ? -b_q : b_q;
        neg     = (is_div && op_q[1]) ? sa : sa ^ sb;
        div0    = is_div && b_q == '0;
        ovf     = is_div && !op_q[0] && a_q == MD_OVF_QUOT && b_q == MD_DIV0_QUOT;
`ifdef MULDIV_ZERO_BYPASS_EN
        zbyp    = is_div ? (a_q == '0 && b_q != '0) : (a_q == '0 || b_q == '0);
`else
        zbyp    = 1'b0;
`endif
        special = div0 || ovf || zbyp;
        spec_val = div0 ? (op_q[1] ? a_q : MD_DIV0_QUOT) :
                   ovf  ? (op_q[1] ? MD_OVF_REM : MD_OVF_QUOT) : '0;
        last    = cnt == MD_CNT_W'(DATA_WIDTH - 1);
    end

    // Sign correction and word selection of the finished datapath result
    always_comb begin
        prod = neg_q ? -{hi, lo} : {hi, lo};
        quot = neg_q ? -lo : lo;
        rem  = neg_q ? -hi : hi;
        fin  = spec_q ? spec_val_q :
               is_div ? (op_q[1] ? rem : quot) :
               (op_q == MD_MUL) ? prod[DATA_WIDTH-1:0] : prod[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    // Next state and handshake outputs; flush outranks advancing, except in DONE
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = (start && !flush) ? S_PREP : S_IDLE;
            S_PREP:  state_d = flush ? S_IDLE : special ? S_DONE : S_RUN;
            S_RUN:   state_d = flush ? S_IDLE : last ? S_DONE : S_RUN;
            default: state_d = S_IDLE;
        endcase
        busy   = state == S_PREP || state == S_RUN;
        stall  = busy || (state == S_IDLE && start);
        done   = state == S_DONE;
        result = done ? fin : res_q;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    // Operand latch, recorded sign/special result, iteration counter and held result
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q       <= MD_MUL;
            a_q        <= '0;
            b_q        <= '0;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            cnt        <= '0;
            res_q      <= '0;
        end else begin
            if (state == S_IDLE && start && !flush) begin
                op_q <= md_op_e'(op);
                a_q  <= srca;
                b_q  <= srcb;
            end
            if (state == S_PREP) begin
                neg_q      <= neg;
                spec_q     <= special;
                spec_val_q <= spec_val;
            end
            cnt <= (state == S_RUN) ? cnt + 1'b1 : '0;
            if (state == S_DONE)
                res_q <= fin;
        end
    end

    muldiv_iter_dp #(.W(DATA_WIDTH)) u_dp (
        .clk   (clk),
        .reset (reset),
        .load  (state == S_PREP),
        .step  (state == S_RUN),
        .mode  (is_div ? MD_MODE_DIV : MD_MODE_MUL),
        .a     (mag_a),
        .b     (mag_b),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer with directed vectors
module tb_muldiv_sequencer;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] srca = '0, srcb = '0;
    logic        stall, busy, done;
    logic [31:0] result;
    int          cyc = 0, n_cmp = 0, n_fail = 0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;

`ifdef MULDIV_ZERO_BYPASS_EN
    localparam int ZL = 2;
`else
    localparam int ZL = 34;
`endif

    muldiv_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .srca   (srca),
        .srcb   (srcb),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 result=%h at cycle %0d, expected no done", result, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("result", result, mon_e.res);
                chk("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int lat);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        sbq.push_back('{r, cyc + lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (sbq.size() != 0 && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat);
        issue(o, a, b, r, lat);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_result", result, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_done", {31'b0, done}, 32'h0);

        // MUL with per-cycle stall profile
        @(negedge clk);
        start = 1'b1;
        op    = 3'd0;
        srca  = 32'd7;
        srcb  = 32'hFFFF_FFFD;
        sbq.push_back('{32'hFFFF_FFEB, cyc + 34});
        for (int k = 0; k <= 34; k++) begin
            #1;
            chk($sformatf("stall_c%0d", k), {31'b0, stall}, (k < 34) ? 32'd1 : 32'd0);
            @(negedge clk);
            start = 1'b0;
        end
        drain();

        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34);
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
        run(3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
        run(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
        run(3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF, 2);
        run(3'd6, 32'd7,         32'd0,         32'd7,         2);
        run(3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
        run(3'd7, 32'd9,         32'd0,         32'd9,         2);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2);
        run(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34);
        run(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        run(3'd0, 32'd0,         32'd5,         32'd0,         ZL);
        run(3'd4, 32'd0,         32'd5,         32'd0,         ZL);
        run(3'd4, 32'd0,         32'd0,         32'hFFFF_FFFF, 2);

        // start pulse while busy must not disturb the running MUL
        issue(3'd0, 32'd3, 32'd4, 32'd12, 34);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        srca  = 32'd99;
        srcb  = 32'd0;
        @(negedge clk);
        start = 1'b0;
        drain();

        // flush in DONE is ignored: done still fires
        issue(3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 2);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drain();

        // flush together with start in IDLE: start is dropped
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = 3'd0;
        srca  = 32'd2;
        srcb  = 32'd2;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", {31'b0, busy}, 32'h0);

        // flush in cycle 10 of a DIV, then immediate restart
        run(3'd5, 32'd100, 32'd7, 32'd14, 34);
        run(3'd7, 32'd100, 32'd7, 32'd2, 34);
        run(3'd5, 32'd100, 32'd7, 32'd14, 34);
        @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        srca  = 32'd100;
        srcb  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'h0);
        chk("flush_stall", {31'b0, stall}, 32'h0);
        chk("flush_result_held", result, 32'd14);
        start = 1'b1;
        op    = 3'd0;
        srca  = 32'd3;
        srcb  = 32'd4;
        sbq.push_back('{32'd12, cyc + 34});
        @(negedge clk);
        start = 1'b0;
        drain();

        // reset in cycle 5 discards the operation and clears the result
        @(negedge clk);
        start = 1'b1;
        op    = 3'd5;
        srca  = 32'd100;
        srcb  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_result", result, 32'h0);
        chk("midreset_busy", {31'b0, busy}, 32'h0);
        chk("midreset_stall", {31'b0, stall}, 32'h0);
        start = 1'b1;
        op    = 3'd0;
        srca  = 32'd6;
        srcb  = 32'd7;
        sbq.push_back('{32'd42, cyc + 34});
        @(negedge clk);
        start = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        chk("final_outstanding", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
